// File: rtl/card_list_reader.sv
// Walks a linked list of cards in card RAM from head_addr and presents each
// card on a valid/ready stream. Read-only user of the RAM port.
module card_list_reader #(
   parameter int RD_LAT    = 1,
   parameter int MAX_CARDS = 52
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic        start,
   input  logic [9:0]  head_addr,
   output logic [9:0]  ram_address,
   input  logic [31:0] ram_q,
   output logic        card_valid,
   input  logic        card_ready,
   output logic [1:0]  card_suit,
   output logic [3:0]  card_value,
   output logic [9:0]  card_addr,
   output logic [5:0]  card_index,
   output logic [5:0]  count,
   output logic        busy,
   output logic        done,
   output logic        error
);

   typedef enum logic [2:0] {
      S_IDLE, S_ISSUE, S_WAIT, S_CHECK, S_PRESENT, S_DONE
   } state_t;

   localparam logic [1:0] LAT_LOAD   = 2'(RD_LAT);
   localparam logic [5:0] LAST_COUNT = 6'(MAX_CARDS - 1);

   state_t     state, state_nx;
   logic [9:0] cur;
   logic [9:0] next_ptr;
   logic [1:0] wait_cnt;
   logic       handshake;
   logic       unused_bits;

   // Reserved word fields are not policed; only the occupied flag is.
   assign unused_bits = ^{ram_q[30:22], ram_q[15:10]};

   // Decoded from the async-reset state register, so card_valid drops the
   // moment resetn falls.
   assign card_valid = (state == S_PRESENT);
   assign busy       = (state != S_IDLE);
   assign done       = (state == S_DONE);
   assign handshake  = card_valid & card_ready;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) state <= S_IDLE;
      else         state <= state_nx;
   end

   // NOTE: state_nx gets a default before the case so no path leaves it
   // unassigned; a missing default here would infer a latch.
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:    if (start) state_nx = (head_addr == '0) ? S_DONE : S_ISSUE;
         S_ISSUE:   state_nx = S_WAIT;
         S_WAIT:    if (wait_cnt == '0) state_nx = S_CHECK;
         S_CHECK:   state_nx = ram_q[31] ? S_PRESENT : S_DONE;
         S_PRESENT: begin
            if (handshake) begin
               if (next_ptr == '0 || count == LAST_COUNT) state_nx = S_DONE;
               else                                       state_nx = S_ISSUE;
            end
         end
         S_DONE:    state_nx = S_IDLE;
         default:   state_nx = S_IDLE;
      endcase
   end

   // NOTE: all sequential state uses non-blocking assignments so every
   // register samples the pre-edge values of the others.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         cur         <= '0;
         next_ptr    <= '0;
         wait_cnt    <= '0;
         ram_address <= '0;
         card_suit   <= '0;
         card_value  <= '0;
         card_addr   <= '0;
         card_index  <= '0;
         count       <= '0;
         error       <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  cur   <= head_addr;
                  count <= '0;
                  error <= 1'b0;
               end
            end
            S_ISSUE: begin
               ram_address <= cur;
               wait_cnt    <= LAT_LOAD;
            end
            S_WAIT: wait_cnt <= wait_cnt - 2'd1;
            S_CHECK: begin
               if (!ram_q[31]) begin
                  error <= 1'b1;
               end else begin
                  card_suit  <= ram_q[21:20];
                  card_value <= ram_q[19:16];
                  card_addr  <= cur;
                  card_index <= count;
                  next_ptr   <= ram_q[9:0];
               end
            end
            S_PRESENT: begin
               if (handshake) begin
                  count <= count + 6'd1;
                  cur   <= next_ptr;
                  // A non-terminated list at the length limit is a loop or corruption.
                  if (next_ptr != '0 && count == LAST_COUNT) error <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
